// File: rtl/my_mips_pkg.sv
// Shared size codes, FSM encoding and the alignment rule for the load/store unit.
package my_mips_pkg;

    localparam int NBITS  = 31;
    localparam int ADDRSZ = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_ERR   = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

    // Illegal size code counts as misaligned so every reject takes one path.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            SZ_ILL:  bad = 1'b1;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/my_lane_align.sv
// Byte-lane steering: extract and extend a load lane, or merge a store lane into a word.
// Latency: purely combinational.
// Backpressure: none; the caller's FSM decides when outputs are used.
module my_lane_align
    import my_mips_pkg::*;
(
    input  logic [1:0]     size,
    input  logic           is_unsigned,
    input  logic [1:0]     offset,
    input  logic [NBITS:0] rdata,
    input  logic [NBITS:0] wdata,
    output logic [NBITS:0] load_data,
    output logic [NBITS:0] merged
);

    logic [4:0]     byte_shift;
    logic [4:0]     half_shift;
    logic [NBITS:0] shifted;
    logic [7:0]     byte_lane;
    logic [15:0]    half_lane;
    logic [NBITS:0] mask;
    logic [NBITS:0] ins;

    assign byte_shift = {offset, 3'b000};
    assign half_shift = {offset[1], 4'b0000};
    assign shifted    = rdata >> byte_shift;
    assign byte_lane  = shifted[7:0];
    assign half_lane  = offset[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        load_data = rdata;
        case (size)
            SZ_BYTE: load_data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
            SZ_HALF: load_data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
            default: load_data = rdata;
        endcase
    end

    always_comb begin
        mask = '1;
        ins  = wdata;
        case (size)
            SZ_BYTE: begin
                mask = 32'h0000_00FF << byte_shift;
                ins  = {24'h0, wdata[7:0]} << byte_shift;
            end
            SZ_HALF: begin
                mask = 32'h0000_FFFF << half_shift;
                ins  = {16'h0, wdata[15:0]} << half_shift;
            end
            default: begin
                mask = '1;
                ins  = wdata;
            end
        endcase
    end

    assign merged = (rdata & ~mask) | (ins & mask);

endmodule

// File: rtl/my_loadstore_unit.sv
// Sequences byte/half/word loads and stores onto a word-only memory; sub-word stores use read-modify-write.
// Latency: load/SW/error respond one cycle after the edge following accept; SB/SH one cycle later.
// Backpressure: req_ready only in IDLE; one request in flight, requester holds req_valid.
module my_loadstore_unit
    import my_mips_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDRSZ+2:0]   req_addr,
    input  logic [NBITS:0]      req_wdata,
    output logic                rsp_valid,
    output logic [NBITS:0]      rsp_rdata,
    output logic                rsp_misalign,
    output logic                mem_we,
    output logic [ADDRSZ:0]     mem_addr,
    output logic [NBITS:0]      mem_wdata,
    input  logic [NBITS:0]      mem_rdata
);

    state_t              state;
    logic                we_q;
    logic [1:0]          size_q;
    logic                uns_q;
    logic [ADDRSZ+2:0]   addr_q;
    logic [NBITS:0]      wdata_q;
    logic [NBITS:0]      load_data;
    logic [NBITS:0]      merged;

    assign req_ready = (state == ST_IDLE);
    assign mem_addr  = addr_q[ADDRSZ+2:2];

    my_lane_align u_align (
        .size        (size_q),
        .is_unsigned (uns_q),
        .offset      (addr_q[1:0]),
        .rdata       (mem_rdata),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged      (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_misalign <= 1'b0;
            mem_we       <= 1'b0;
            mem_wdata    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (is_misaligned(req_size, req_addr[1:0])) begin
                            state <= ST_ERR;
                        end else if (!req_we) begin
                            state <= ST_LOAD;
                        end else if (req_size == SZ_WORD) begin
                            mem_wdata <= req_wdata;
                            mem_we    <= 1'b1;
                            state     <= ST_WRITE;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end
                ST_LOAD: begin
                    rsp_rdata <= load_data;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                // mem_rdata is the current word at the latched address; write back the merge next cycle.
                ST_READ: begin
                    mem_wdata <= merged;
                    mem_we    <= 1'b1;
                    state     <= ST_WRITE;
                end
                ST_WRITE: begin
                    mem_we    <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_ERR: begin
                    rsp_rdata    <= '0;
                    rsp_misalign <= 1'b1;
                    rsp_valid    <= 1'b1;
                    state        <= ST_RESP;
                end
                ST_RESP: begin
                    rsp_valid    <= 1'b0;
                    rsp_misalign <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: begin
                    mem_we <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
